// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, data-enable and line/frame
// strobes from HS/VS/BLANK_N in the pixel-clock domain, measures line and
// frame totals and reports lock against the expected video mode.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_blank_n,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_de,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [11:0] o_h_total,
  output logic [10:0] o_v_total,
  output logic        o_locked,
  output logic        o_err
);

  localparam logic [11:0] H_EXP  = 12'(H_TOTAL);
  localparam logic [10:0] V_EXP  = 11'(V_TOTAL);
  localparam logic [4:0]  LOCK_N = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state;
  logic        hs_q, hs_p, vs_q, vs_p;
  logic        hs_edge, vs_edge;
  logic [11:0] h_cnt;
  logic [10:0] v_line;
  logic [11:0] h_total_next;
  logic [10:0] v_count;
  logic        line_de;
  logic [3:0]  good_cnt;
  logic        hv_seen;
  logic        frame_bad;
  logic        h_bad, v_bad, timeout;

  // Sync sampling; the history registers reset to the asserted level so a
  // source already in sync at reset release never yields a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= SYNC_POL;
      hs_p <= SYNC_POL;
      vs_q <= SYNC_POL;
      vs_p <= SYNC_POL;
    end else begin
      hs_q <= i_hs;
      hs_p <= hs_q;
      vs_q <= i_vs;
      vs_p <= vs_q;
    end
  end

  // Edge detection, measurement values and check conditions.
  always_comb begin
    hs_edge      = (hs_q == SYNC_POL) && (hs_p != SYNC_POL);
    vs_edge      = (vs_q == SYNC_POL) && (vs_p != SYNC_POL);
    h_total_next = (h_cnt == '1) ? '1 : h_cnt + 12'd1;
    v_count      = (hs_edge && (v_line != '1)) ? v_line + 11'd1 : v_line;
    h_bad        = hs_edge && hv_seen && (h_total_next != H_EXP);
    v_bad        = vs_edge && (v_count != V_EXP);
    timeout      = (!hs_edge && (h_cnt == 12'd4094)) ||
                   (hs_edge && !vs_edge && (v_line == 11'd2046));
  end

  // Line and frame length counters with their latched totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_line    <= '0;
      o_h_total <= '0;
      o_v_total <= '0;
    end else begin
      if (hs_edge) begin
        h_cnt     <= '0;
        o_h_total <= h_total_next;
      end else if (h_cnt != '1) begin
        h_cnt <= h_cnt + 12'd1;
      end
      if (vs_edge) begin
        v_line    <= '0;
        o_v_total <= v_count;
      end else begin
        v_line <= v_count;
      end
    end
  end

  // Pixel coordinates, data-enable and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      line_de       <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_de          <= i_blank_n;
      o_line_start  <= hs_edge;
      o_frame_start <= vs_edge;
      line_de       <= hs_edge ? 1'b0 : (line_de | o_de);
      if (hs_edge)
        o_x <= '0;
      else if (o_de && (o_x != '1))
        o_x <= o_x + 10'd1;
      if (vs_edge)
        o_y <= '0;
      else if (hs_edge && (line_de || o_de) && (o_y != '1))
        o_y <= o_y + 10'd1;
    end
  end

  // Lock FSM; a mismatch at a VS edge closes that frame, so the next frame
  // starts clean rather than inheriting frame_bad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      hv_seen   <= 1'b0;
      frame_bad <= 1'b0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (timeout) begin
        o_err     <= 1'b1;
        o_locked  <= 1'b0;
        state     <= SEARCH;
        good_cnt  <= '0;
        hv_seen   <= 1'b0;
        frame_bad <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (vs_edge) begin
              state     <= TRACK;
              good_cnt  <= '0;
              hv_seen   <= 1'b0;
              frame_bad <= 1'b0;
            end
          end
          TRACK, LOCKED: begin
            if (hs_edge)
              hv_seen <= 1'b1;
            if (h_bad || v_bad) begin
              o_err     <= 1'b1;
              o_locked  <= 1'b0;
              state     <= TRACK;
              good_cnt  <= '0;
              frame_bad <= !vs_edge;
            end else if (vs_edge) begin
              frame_bad <= 1'b0;
              if ((state == TRACK) && !frame_bad) begin
                if (({1'b0, good_cnt} + 5'd1) >= LOCK_N) begin
                  state    <= LOCKED;
                  o_locked <= 1'b1;
                end else begin
                  good_cnt <= good_cnt + 4'd1;
                end
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of vga_sync_decoder using a reduced
// 20x12 video mode (8x6 active, HS at x 10..12, VS over lines 8..9).
module tb_vga_sync_decoder;

  localparam int H = 20;
  localparam int V = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_hs, i_vs, i_blank_n;
  logic [9:0]  o_x, o_y;
  logic        o_de, o_line_start, o_frame_start, o_locked, o_err;
  logic [11:0] o_h_total;
  logic [10:0] o_v_total;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(H), .V_TOTAL(V), .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_blank_n(i_blank_n),
    .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_line_start(o_line_start),
    .o_frame_start(o_frame_start), .o_h_total(o_h_total),
    .o_v_total(o_v_total), .o_locked(o_locked), .o_err(o_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Video source model
  int gx = 0, gy = 0, last_x = -1, last_y = -1;
  int vs_off = 0;
  int stretch_line = -1;
  bit sync_hold = 1'b0;

  task automatic drive_px();
    int hl, lin, vs0;
    hl  = (gy == stretch_line) ? H + 1 : H;
    lin = gy * H + ((gx < H) ? gx : H - 1);
    vs0 = 8 * H + 10 + vs_off;
    i_hs      = sync_hold ? 1'b1 : !(gx >= 10 && gx < 13);
    i_vs      = sync_hold ? 1'b1 : !(lin >= vs0 && lin < vs0 + 2 * H);
    i_blank_n = (gx < 8) && (gy < 6);
    last_x = gx;
    last_y = gy;
    gx++;
    if (gx >= hl) begin
      gx = 0;
      if (gy == stretch_line) stretch_line = -1;
      gy = (gy == V - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drive_px();
  endtask

  // Event monitor
  int   cyc = 0, err_cnt = 0, fs_cnt = 0, fs_t_last = 0, fs_t_prev = 0;
  int   lock_fs = 0;
  logic locked_d = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_err) err_cnt <= err_cnt + 1;
    if (o_frame_start) begin
      fs_cnt    <= fs_cnt + 1;
      fs_t_prev <= fs_t_last;
      fs_t_last <= cyc;
    end
    if (o_locked && !locked_d) lock_fs <= fs_cnt + (o_frame_start ? 1 : 0);
    locked_d <= o_locked;
  end

  task automatic wait_fs(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      if (o_frame_start) seen = 1'b1;
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic wait_err(input string tag, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      if (o_err) seen = 1'b1;
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic advance_to(input int y, input int x);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      if (last_y == y && last_x == x) seen = 1'b1;
    end
    check_eq("advance", seen, 1);
  endtask

  int e0;

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d reached limit 50000", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_hs = 1'b1; i_vs = 1'b1; i_blank_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_x", o_x, 0);
    check_eq("rst_y", o_y, 0);
    check_eq("rst_de", o_de, 0);
    check_eq("rst_ls", o_line_start, 0);
    check_eq("rst_fs", o_frame_start, 0);
    check_eq("rst_htot", o_h_total, 0);
    check_eq("rst_vtot", o_v_total, 0);
    check_eq("rst_lock", o_locked, 0);
    check_eq("rst_err", o_err, 0);
    rst = 1'b0;

    // Acquisition from reset
    for (int f = 0; f < 5; f++) wait_fs("acq_fs");
    tick(); tick();
    check_eq("lock_at_fs", lock_fs, 3);
    check_eq("fs_period", fs_t_last - fs_t_prev, H * V);
    check_eq("h_total", o_h_total, H);
    check_eq("v_total", o_v_total, V);
    check_eq("locked", o_locked, 1);
    check_eq("no_err", err_cnt, 0);

    // Last active pixel of a frame
    advance_to(5, 7);
    tick();
    check_eq("last_de", o_de, 1);
    check_eq("last_x", o_x, 7);
    check_eq("last_y", o_y, 5);
    tick();
    check_eq("post_de", o_de, 0);
    check_eq("post_x", o_x, 8);
    wait_fs("fs_after_last");
    check_eq("y_clear", o_y, 0);
    check_eq("x_clear", o_x, 0);
    check_eq("coinc_ls", o_line_start, 1);

    // One stretched line
    stretch_line = 3;
    e0 = err_cnt;
    wait_err("stretch_err", 400);
    check_eq("stretch_lock", o_locked, 0);
    check_eq("stretch_htot", o_h_total, H + 1);
    check_eq("stretch_ls", o_line_start, 1);
    wait_fs("relock_fs1"); check_eq("relock_l1", o_locked, 0);
    wait_fs("relock_fs2"); check_eq("relock_l2", o_locked, 0);
    wait_fs("relock_fs3"); check_eq("relock_l3", o_locked, 1);
    tick();
    check_eq("stretch_errs", err_cnt - e0, 1);

    // Loss of sync: HS timeout
    advance_to(0, 0);
    sync_hold = 1'b1;
    e0 = err_cnt;
    wait_err("tmo_err", 5000);
    check_eq("tmo_lock", o_locked, 0);
    repeat (300) tick();
    check_eq("tmo_once", err_cnt - e0, 1);
    check_eq("tmo_lock2", o_locked, 0);
    advance_to(V - 1, H - 1);
    sync_hold = 1'b0;
    wait_fs("rs_fs1"); check_eq("rs_l1", o_locked, 0);
    wait_fs("rs_fs2"); check_eq("rs_l2", o_locked, 0);
    wait_fs("rs_fs3"); check_eq("rs_l3", o_locked, 1);
    check_eq("rs_htot", o_h_total, H);

    // VS 16 clocks after HS, then back to coincident
    e0 = err_cnt;
    advance_to(V - 1, H - 1);
    vs_off = 16;
    wait_fs("off_fs1");
    check_eq("off_ls", o_line_start, 0);
    check_eq("off_y", o_y, 0);
    check_eq("off_vtot1", o_v_total, V);
    wait_fs("off_fs2");
    check_eq("off_vtot2", o_v_total, V);
    check_eq("off_lock", o_locked, 1);
    advance_to(V - 1, H - 1);
    vs_off = 0;
    wait_fs("on_fs");
    check_eq("on_vtot", o_v_total, V);
    check_eq("on_lock", o_locked, 1);
    tick();
    check_eq("off_errs", err_cnt - e0, 0);

    // Asynchronous reset mid-line while locked
    advance_to(3, 4);
    rst = 1'b1;
    #1;
    check_eq("arst_lock", o_locked, 0);
    check_eq("arst_x", o_x, 0);
    check_eq("arst_y", o_y, 0);
    check_eq("arst_de", o_de, 0);
    check_eq("arst_htot", o_h_total, 0);
    check_eq("arst_vtot", o_v_total, 0);
    tick(); tick(); tick();
    rst = 1'b0;
    e0 = err_cnt;
    wait_fs("ar_fs1"); check_eq("ar_l1", o_locked, 0);
    wait_fs("ar_fs2"); check_eq("ar_l2", o_locked, 0);
    wait_fs("ar_fs3"); check_eq("ar_l3", o_locked, 1);
    tick();
    check_eq("ar_errs", err_cnt - e0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
